// File: rtl/ram64_arbiter_if.sv
// Requester-side handshake bundle for ram64_arbiter: one request channel
// (valid/ready with we/addr/wdata) and its one-cycle response pulse.
interface ram64_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
);
    logic              valid;
    logic              ready;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram64_arbiter.sv
// Round-robin two-requester controller for a single-port 64x16 ram64.
// Optional power-up zero sweep of the RAM is compiled in with RAM64_ARB_INIT_EN.
module ram64_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    ram64_arbiter_if.slave    a_if,
    ram64_arbiter_if.slave    b_if,
    output logic [DATA_W-1:0] ram_in,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out,
    output logic              busy
);

`ifdef RAM64_ARB_INIT_EN
    typedef enum logic [2:0] {IDLE, WR, RD, RESP, INIT} state_t;
    localparam state_t RST_STATE = INIT;
`else
    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    localparam logic       OWN_A   = 1'b0;
    localparam logic       OWN_B   = 1'b1;
    localparam logic [1:0] RD_LAST = 2'(READ_LATENCY - 1);

    state_t            state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        cnt_q;
    logic              a_rsp_valid_q, b_rsp_valid_q;
    logic [DATA_W-1:0] a_rsp_rdata_q, b_rsp_rdata_q;
    logic              ram_load_q;
    logic [ADDR_W-1:0] ram_address_q;
    logic [DATA_W-1:0] ram_in_q;
`ifdef RAM64_ARB_INIT_EN
    logic [ADDR_W-1:0] init_cnt_q;
`endif

    logic              idle_ok, a_grant, b_grant, hs;
    logic              owner_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;

    // Grants are only offered in IDLE and never while reset is held.
    assign idle_ok = rst_n & (state_q == IDLE);
    assign a_grant = a_if.valid & (~b_if.valid | (last_grant_q == OWN_B));
    assign b_grant = b_if.valid & (~a_if.valid | (last_grant_q == OWN_A));
    assign a_if.ready = idle_ok & a_grant;
    assign b_if.ready = idle_ok & b_grant;
    assign hs = a_if.ready | b_if.ready;

    always_comb begin
        owner_d = OWN_A;
        we_d    = a_if.we;
        addr_d  = a_if.addr;
        wdata_d = a_if.wdata;
        if (b_if.ready) begin
            owner_d = OWN_B;
            we_d    = b_if.we;
            addr_d  = b_if.addr;
            wdata_d = b_if.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RST_STATE;
            last_grant_q  <= OWN_B;
            owner_q       <= OWN_A;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt_q         <= '0;
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            a_rsp_rdata_q <= '0;
            b_rsp_rdata_q <= '0;
            ram_load_q    <= 1'b0;
            ram_address_q <= '0;
            ram_in_q      <= '0;
`ifdef RAM64_ARB_INIT_EN
            init_cnt_q    <= '0;
`endif
        end else begin
            a_rsp_valid_q <= 1'b0;
            b_rsp_valid_q <= 1'b0;
            ram_load_q    <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (hs) begin
                        owner_q       <= owner_d;
                        we_q          <= we_d;
                        addr_q        <= addr_d;
                        wdata_q       <= wdata_d;
                        last_grant_q  <= owner_d;
                        ram_address_q <= addr_d;
                        ram_in_q      <= wdata_d;
                        cnt_q         <= RD_LAST;
                        if (we_d) begin
                            ram_load_q <= 1'b1;
                            state_q    <= WR;
                        end else begin
                            state_q    <= RD;
                        end
                    end
                end
                WR: begin
                    a_rsp_valid_q <= (owner_q == OWN_A);
                    b_rsp_valid_q <= (owner_q == OWN_B);
                    state_q       <= RESP;
                end
                RD: begin
                    // The final RD edge is the one where ram_out holds the addressed word.
                    if (cnt_q == '0) begin
                        if (owner_q == OWN_A) a_rsp_rdata_q <= ram_out;
                        else                  b_rsp_rdata_q <= ram_out;
                        a_rsp_valid_q <= (owner_q == OWN_A);
                        b_rsp_valid_q <= (owner_q == OWN_B);
                        state_q       <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
`ifdef RAM64_ARB_INIT_EN
                INIT: begin
                    init_cnt_q <= init_cnt_q + ADDR_W'(1);
                    if (&init_cnt_q) state_q <= IDLE;
                end
`endif
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign a_if.rsp_valid = a_rsp_valid_q;
    assign b_if.rsp_valid = b_rsp_valid_q;
    assign a_if.rsp_rdata = a_rsp_rdata_q;
    assign b_if.rsp_rdata = b_rsp_rdata_q;
    assign busy           = (state_q != IDLE);

    // A write in flight is suppressed in the same cycle reset is asserted.
`ifdef RAM64_ARB_INIT_EN
    assign ram_load    = rst_n & (ram_load_q | (state_q == INIT));
    assign ram_address = (state_q == INIT) ? init_cnt_q : ram_address_q;
    assign ram_in      = (state_q == INIT) ? '0 : ram_in_q;
`else
    assign ram_load    = rst_n & ram_load_q;
    assign ram_address = ram_address_q;
    assign ram_in      = ram_in_q;
`endif

endmodule
